tmr_fault_monitor: RTL and testbench
====================================

# tmr_fault_monitor

Observer for a triple-modular-redundant (TMR) datapath. It samples the three replica outputs alongside the voter, computes a bitwise majority and a per-replica mismatch mask, and classifies each upset as single (correctable) or multiple (uncorrectable). Each upset is reported as a timestamped event through a small valid/ready event queue. The block also keeps saturating per-replica error counters and sticky status flags. It sits beside the voter and receives the same replica buses; it never drives the datapath.

## Interface
- WIDTH, 16, replica bus width
- CNT_W, 8, per-replica error counter width
- TS_W, 16, timestamp width
- DEPTH, 4, event queue depth (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset; rst, asynchronous, active-high; clock clk
- q_1, q_2, q_3  in  WIDTH  replica outputs
- sample_en  in  1  compare replicas this cycle
- clr  in  1  synchronous clear of counters, flags, timestamp and queue
- evt_valid  out  1  queue head valid
- evt_ready  in  1  consumer accepts head
- evt_mask  out  3  head mismatch mask; bit i-1 set means replica i disagreed
- evt_class  out  2  head class: 01 single, 10 multiple
- evt_ts  out  TS_W  head timestamp
- err_cnt_1, err_cnt_2, err_cnt_3  out  CNT_W  saturating per-replica error counts
- uncorrectable  out  1  sticky; a multiple-class upset has been detected
- overflow  out  1  sticky; an event was dropped because the queue was full

## Operation
- Timestamp: free-running counter. It increments every cycle and wraps from 2^TS_W-1 to 0.
- Stage 1: on a clock edge with sample_en=1, the block registers q_1..q_3, the current timestamp, and a stage-valid bit. With sample_en=0, stage-valid is cleared.
- Stage 2, combinational from the stage-1 registers:
  - maj = (a&b)|(a&c)|(b&c)
  - mask[i] = (q_i != maj)
  - class = 01 if popcount(mask)==1; 10 if popcount(mask)≥2; 00 otherwise.
- Event condition: stage-valid, mask≠0, and mask≠last_mask.
  - last_mask holds the mask of the most recent valid sample and updates on every valid sample, including all-zero masks.
  - A persistent fault is therefore logged once. A fault that clears and then recurs is logged again.
- When an event fires, at the same edge:
  - The block pushes {mask, class, ts} into the queue.
  - err_cnt_i increments for each set mask bit. Each counter saturates at 2^CNT_W-1.
  - uncorrectable is set if class=10.
- Queue full on push: the event is dropped and overflow is set. Counters and uncorrectable still update.
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
- The queue has no bypass; an empty queue shows evt_valid=0.
- Handshake: the head transfers on an edge where evt_valid=1 and evt_ready=1. evt_mask, evt_class and evt_ts stay stable while evt_valid=1 and evt_ready=0.
- clr has priority over everything. At the edge it:
  - flushes the queue;
  - zeroes the counters, timestamp and last_mask;
  - clears both sticky flags and stage-valid.
  Any event pending in that cycle is discarded.

## Timing
- Reset values: evt_valid=0, evt_mask=0, evt_class=0, evt_ts=0, err_cnt_*=0, uncorrectable=0, overflow=0. Reset also zeroes the timestamp, last_mask, stage-valid and the queue pointers.
- Latency: replicas sampled at edge N (timestamp value T captured). The event is visible with evt_valid=1 and evt_ts=T after edge N+1 when the queue was empty. Counters and flags update at edge N+1.
- Throughput: one event per cycle sustained while the consumer holds evt_ready=1.
- Reset asserted mid-operation clears all state immediately, independent of clk.

## Structure
- Package tmr_mon_pkg holds:
  - evt_class_t enum: NONE=00, SINGLE=01, MULTI=10;
  - tmr_evt_t packed struct {mask[2:0], class, ts};
  - a popcount3 function.
- Sub-module tmr_event_fifo: parameterized by DEPTH and tmr_evt_t. It uses a register array with read/write pointers plus one extra wrap bit. It provides push, full, pop, valid and a synchronous flush.
- Top level holds stage 1, the majority/mask logic, last_mask, the counters, the timestamp and the sticky flags.

## Test plan
- Reset, then sample_en=1 with q_1=q_2=q_3=16'h1234 for 10 cycles -> evt_valid stays 0, all counters 0, both flags 0.
- q_2=16'h1235 for one sampled cycle at timestamp 5 -> one event with mask=3'b010, class=01, ts=5, valid after the following edge; err_cnt_2=1.
- q_2 held wrong for 6 sampled cycles -> exactly one event; err_cnt_2=1.
- q_1=16'h0001, q_2=16'h0002, q_3=16'h0004 -> maj=0, mask=3'b111, class=10; uncorrectable=1; all three counters increment.
- evt_ready=0 with 5 distinct events -> the queue holds 4 events in order, the 5th is dropped and overflow=1. Then set evt_ready=1 -> the 4 events drain one per cycle with payloads unchanged.
- 255 single-fault events on replica 3, then one more -> err_cnt_3 stays 8'hFF. Then pulse clr -> counters, flags and evt_valid are 0, and the timestamp restarts at 0.

Source files
------------

// File: rtl/tmr_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_mon_pkg
// Description : Shared types and helpers for the TMR fault monitor.
//               - evt_class_t : upset classification (NONE / SINGLE / MULTI)
//               - tmr_evt_t   : queued event record {mask, cls, ts}
//               - popcount3   : number of set bits in a 3-bit mask
// Revision    : 1.0 - initial release
// ============================================================================
package tmr_mon_pkg;

  localparam int TMR_TS_W = 16;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    SINGLE = 2'b01,
    MULTI  = 2'b10
  } evt_class_t;

  // Default event record; the top level builds its own copy sized by TS_W.
  typedef struct packed {
    logic [2:0]          mask;
    evt_class_t          cls;
    logic [TMR_TS_W-1:0] ts;
  } tmr_evt_t;

  function automatic logic [1:0] popcount3(input logic [2:0] m);
    popcount3 = {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tmr_event_fifo
// Description : Small register-array event queue with read/write pointers
//               carrying one extra wrap bit. A push into a full queue is
//               accepted when a pop happens at the same edge. flush is
//               synchronous and empties the queue.
// Ports       : clk, rst (async, active-high), flush, push/push_data/full,
//               pop/valid/head
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_event_fifo
  import tmr_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type EVT_T = tmr_evt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  EVT_T push_data,
  output logic full,
  input  logic pop,
  output logic valid,
  output EVT_T head
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  EVT_T        mem_q [DEPTH];
  EVT_T        mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Same index with different wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid = (wr_ptr_q != rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && valid;
    // When full, a simultaneous pop frees the slot the push lands in.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmr_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tmr_fault_monitor
// Description : Passive observer for a triple-modular-redundant datapath.
//               Registers the three replicas, forms the bitwise majority and
//               a per-replica mismatch mask, classifies upsets as single or
//               multiple, and queues timestamped events. Keeps saturating
//               per-replica error counters and sticky status flags.
// Ports       : clk, rst (async, active-high)
//               q_1..q_3 [WIDTH]      replica buses
//               sample_en             compare replicas this cycle
//               clr                   synchronous clear of all state
//               evt_valid/evt_ready   event queue handshake
//               evt_mask/class/ts     queue head payload (zero when empty)
//               err_cnt_1..3 [CNT_W]  saturating per-replica error counts
//               uncorrectable         sticky: multiple-class upset seen
//               overflow              sticky: event dropped on full queue
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             sample_en,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_mask,
  output logic [1:0]       evt_class,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3,
  output logic             uncorrectable,
  output logic             overflow
);

  typedef struct packed {
    logic [2:0]      mask;
    evt_class_t      cls;
    logic [TS_W-1:0] ts;
  } evt_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

  // Free-running timestamp and stage-1 capture registers
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic [TS_W-1:0]  s1_ts_q, s1_ts_d;
  logic             s1_valid_q, s1_valid_d;

  // Event bookkeeping
  logic [2:0]       last_mask_q, last_mask_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             unc_q, unc_d;
  logic             ovf_q, ovf_d;

  // Stage-2 combinational evaluation
  logic [WIDTH-1:0] maj;
  logic [2:0]       mask;
  logic [1:0]       mask_pop;
  evt_class_t       cls;
  logic             fire;
  logic             push;
  evt_t             push_data;

  // Queue interface
  logic             fifo_full;
  logic             fifo_valid;
  evt_t             fifo_head;

  assign maj      = (s1_a_q & s1_b_q) | (s1_a_q & s1_c_q) | (s1_b_q & s1_c_q);
  assign mask     = {s1_c_q != maj, s1_b_q != maj, s1_a_q != maj};
  assign mask_pop = popcount3(mask);
  assign cls      = (mask_pop == 2'd0) ? NONE :
                    (mask_pop == 2'd1) ? SINGLE : MULTI;
  // Only a change in the mismatch pattern is reported, so a stuck replica
  // produces one event rather than one per cycle.
  assign fire     = s1_valid_q && (mask != 3'b000) && (mask != last_mask_q);
  assign push     = fire && !clr;
  assign push_data = '{mask: mask, cls: cls, ts: s1_ts_q};

  always_comb begin
    ts_d        = ts_q + TS_ONE;
    s1_valid_d  = sample_en;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    s1_ts_d     = s1_ts_q;
    last_mask_d = last_mask_q;
    cnt_d       = cnt_q;
    unc_d       = unc_q;
    ovf_d       = ovf_q;

    if (sample_en) begin
      s1_a_d  = q_1;
      s1_b_d  = q_2;
      s1_c_d  = q_3;
      s1_ts_d = ts_q;
    end

    if (s1_valid_q) begin
      last_mask_d = mask;
    end

    if (fire) begin
      for (int i = 0; i < 3; i++) begin
        if (mask[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      if (cls == MULTI) begin
        unc_d = 1'b1;
      end
      // A pop at the same edge makes room, so only a stalled full queue drops.
      if (fifo_full && !evt_ready) begin
        ovf_d = 1'b1;
      end
    end

    if (clr) begin
      ts_d        = '0;
      s1_valid_d  = 1'b0;
      last_mask_d = '0;
      for (int i = 0; i < 3; i++) begin
        cnt_d[i] = '0;
      end
      unc_d       = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q        <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_ts_q     <= '0;
      s1_valid_q  <= 1'b0;
      last_mask_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      unc_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_ts_q     <= s1_ts_d;
      s1_valid_q  <= s1_valid_d;
      last_mask_q <= last_mask_d;
      cnt_q       <= cnt_d;
      unc_q       <= unc_d;
      ovf_q       <= ovf_d;
    end
  end

  tmr_event_fifo #(
    .DEPTH (DEPTH),
    .EVT_T (evt_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clr),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (evt_ready),
    .valid     (fifo_valid),
    .head      (fifo_head)
  );

  // Payload is forced to zero while the queue is empty so stale entries
  // never appear on the outputs.
  assign evt_valid     = fifo_valid;
  assign evt_mask      = fifo_valid ? fifo_head.mask : 3'b000;
  assign evt_class     = fifo_valid ? fifo_head.cls  : NONE;
  assign evt_ts        = fifo_valid ? fifo_head.ts   : '0;
  assign err_cnt_1     = cnt_q[0];
  assign err_cnt_2     = cnt_q[1];
  assign err_cnt_3     = cnt_q[2];
  assign uncorrectable = unc_q;
  assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tmr_fault_monitor
// Description : Scoreboard bench for tmr_fault_monitor. The driver pushes the
//               hand-computed event expected from each faulty sample; a
//               monitor compares the queue head on every cycle it is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] q_1, q_2, q_3;
  logic        sample_en, clr, evt_ready;
  logic        evt_valid;
  logic [2:0]  evt_mask;
  logic [1:0]  evt_class;
  logic [15:0] evt_ts;
  logic [7:0]  err_cnt_1, err_cnt_2, err_cnt_3;
  logic        uncorrectable, overflow;

  always #5 clk = ~clk;

  tmr_fault_monitor #(
    .WIDTH (16),
    .CNT_W (8),
    .TS_W  (16),
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .q_1           (q_1),
    .q_2           (q_2),
    .q_3           (q_3),
    .sample_en     (sample_en),
    .clr           (clr),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_mask      (evt_mask),
    .evt_class     (evt_class),
    .evt_ts        (evt_ts),
    .err_cnt_1     (err_cnt_1),
    .err_cnt_2     (err_cnt_2),
    .err_cnt_3     (err_cnt_3),
    .uncorrectable (uncorrectable),
    .overflow      (overflow)
  );

  typedef struct {
    logic [2:0]  mask;
    logic [1:0]  cls;
    logic [15:0] ts;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_ts    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [2:0] m, input logic [1:0] c, input logic [15:0] t);
    exp_t e;
    e.mask = m;
    e.cls  = c;
    e.ts   = t;
    sb_q.push_back(e);
  endtask

  // Entered at posedge+1: apply inputs, take one edge, track the timestamp.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic en, input logic cl);
    q_1       = a;
    q_2       = b;
    q_3       = c;
    sample_en = en;
    clr       = cl;
    @(posedge clk);
    tb_ts = cl ? 0 : ((tb_ts + 1) & 16'hFFFF);
    #1;
  endtask

  task automatic good();
    step(16'h1234, 16'h1234, 16'h1234, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    step(16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || evt_valid) && n < 50) begin
      idle();
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // Monitor: compares the head whenever the DUT presents an event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr && evt_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_evt: got mask=%b class=%b ts=%0d expected no event",
                 evt_mask, evt_class, evt_ts);
      end else begin
        e = sb_q[0];
        n_checks++;
        if (evt_mask !== e.mask || evt_class !== e.cls || evt_ts !== e.ts) begin
          n_fail++;
          $display("FAIL %s: got mask=%b class=%b ts=%0d expected mask=%b class=%b ts=%0d",
                   evt_ready ? "evt_pop" : "evt_hold",
                   evt_mask, evt_class, evt_ts, e.mask, e.cls, e.ts);
        end
        if (evt_ready) begin
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    sample_en = 1'b0;
    evt_ready = 1'b1;
    q_1 = '0; q_2 = '0; q_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_mask",  evt_mask, 0);
    chk("rst_class", evt_class, 0);
    chk("rst_ts",    evt_ts, 0);
    chk("rst_cnt",   {err_cnt_1, err_cnt_2, err_cnt_3}, 0);
    chk("rst_flags", {uncorrectable, overflow}, 0);
    rst   = 1'b0;
    tb_ts = 0;

    // Clean samples, then a single fault on replica 2 captured at ts 5
    for (int i = 0; i < 5; i++) good();
    chk("clean_cnt",   {err_cnt_1, err_cnt_2, err_cnt_3}, 0);
    chk("clean_flags", {uncorrectable, overflow}, 0);
    chk("clean_valid", evt_valid, 0);
    expect_evt(3'b010, 2'b01, 16'd5);
    step(16'h1234, 16'h1235, 16'h1234, 1'b1, 1'b0);
    chk("no_early_evt", evt_valid, 0);
    good();
    chk("evt_latency", evt_valid, 1);
    chk("single_cnt2", err_cnt_2, 1);
    for (int i = 0; i < 4; i++) good();
    wait_drain("drain_single");
    chk("single_cnt13", {err_cnt_1, err_cnt_3}, 0);
    chk("single_flags", {uncorrectable, overflow}, 0);

    // Persistent fault logs once
    do_clr();
    chk("clr_cnt2", err_cnt_2, 0);
    expect_evt(3'b010, 2'b01, 16'(tb_ts));
    for (int i = 0; i < 6; i++) step(16'h1234, 16'h1235, 16'h1234, 1'b1, 1'b0);
    good();
    good();
    wait_drain("drain_persist");
    chk("persist_cnt2", err_cnt_2, 1);

    // All three disagree: majority 0, multiple-class
    expect_evt(3'b111, 2'b10, 16'(tb_ts));
    step(16'h0001, 16'h0002, 16'h0004, 1'b1, 1'b0);
    good();
    good();
    chk("multi_unc", uncorrectable, 1);
    chk("multi_cnts", {err_cnt_1, err_cnt_2, err_cnt_3}, {8'd1, 8'd2, 8'd1});
    wait_drain("drain_multi");

    // Stalled consumer: four queued, fifth dropped, then push-with-pop on full
    do_clr();
    chk("clr_unc", uncorrectable, 0);
    evt_ready = 1'b0;
    expect_evt(3'b001, 2'b01, 16'(tb_ts));
    step(16'h1235, 16'h1234, 16'h1234, 1'b1, 1'b0);
    expect_evt(3'b010, 2'b01, 16'(tb_ts));
    step(16'h1234, 16'h1235, 16'h1234, 1'b1, 1'b0);
    expect_evt(3'b100, 2'b01, 16'(tb_ts));
    step(16'h1234, 16'h1234, 16'h1235, 1'b1, 1'b0);
    expect_evt(3'b011, 2'b10, 16'(tb_ts));
    step(16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0);
    step(16'h0001, 16'h0002, 16'h0004, 1'b1, 1'b0);
    expect_evt(3'b100, 2'b01, 16'(tb_ts));
    step(16'h1234, 16'h1234, 16'h1235, 1'b1, 1'b0);
    chk("full_ovf", overflow, 1);
    chk("full_valid", evt_valid, 1);
    evt_ready = 1'b1;
    good();
    for (int i = 0; i < 4; i++) idle();
    chk("drain_rate_valid", evt_valid, 0);
    chk("drain_rate_sb", sb_q.size(), 0);
    chk("stall_unc", uncorrectable, 1);

    // Counter saturation on replica 3
    do_clr();
    chk("clr_ovf", overflow, 0);
    for (int i = 0; i < 255; i++) begin
      expect_evt(3'b100, 2'b01, 16'(tb_ts));
      step(16'h1234, 16'h1234, 16'h1235, 1'b1, 1'b0);
      good();
    end
    good();
    chk("cnt3_255", err_cnt_3, 8'hFF);
    expect_evt(3'b100, 2'b01, 16'(tb_ts));
    step(16'h1234, 16'h1234, 16'h1235, 1'b1, 1'b0);
    good();
    good();
    chk("cnt3_sat", err_cnt_3, 8'hFF);
    chk("sat_cnt12", {err_cnt_1, err_cnt_2}, 0);
    wait_drain("drain_sat");

    // clr discards the pending event and restarts the timestamp
    step(16'h1235, 16'h1234, 16'h1234, 1'b1, 1'b0);
    do_clr();
    chk("clr_all_cnt", {err_cnt_1, err_cnt_2, err_cnt_3}, 0);
    chk("clr_all_flags", {uncorrectable, overflow}, 0);
    chk("clr_valid", evt_valid, 0);
    expect_evt(3'b001, 2'b01, 16'd0);
    step(16'h1235, 16'h1234, 16'h1234, 1'b1, 1'b0);
    good();
    wait_drain("drain_ts_restart");

    // Asynchronous reset clears a queued event without a clock edge
    evt_ready = 1'b0;
    expect_evt(3'b010, 2'b01, 16'(tb_ts));
    step(16'h1234, 16'h1235, 16'h1234, 1'b1, 1'b0);
    good();
    chk("pre_rst_valid", evt_valid, 1);
    rst = 1'b1;
    #2;
    chk("async_rst_valid", evt_valid, 0);
    chk("async_rst_cnt2", err_cnt_2, 0);
    sb_q.delete();
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
